tabla_sweep_checker: RTL



---
 rtl/tabla_pkg.sv | 15 +
 rtl/tabla_settle_timer.sv | 34 +++
 rtl/tabla_sweep_checker.sv | 134 +++++++++++++
 3 files changed

// File: rtl/tabla_pkg.sv
// Shared constants for the truth-table sweep checker: state encoding, row count helper, settle width.
package tabla_pkg;

  localparam int unsigned SETTLE_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  function automatic int unsigned num_vec(input int unsigned n);
    return 32'(1) << n;
  endfunction

endpackage

// File: rtl/tabla_settle_timer.sv
// Loadable down-counter giving a one-cycle expire strobe after SETTLE_CYCLES enabled cycles.
module tabla_settle_timer
  import tabla_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire_c,
  output logic skip_c
);

  // Loaded one short so expire fires on the last settle cycle itself.
  localparam logic [SETTLE_W-1:0] LOAD_VAL =
    (SETTLE_CYCLES == 0) ? '0 : SETTLE_W'(SETTLE_CYCLES - 1);

  logic [SETTLE_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - SETTLE_W'(1);
    end
  end

  assign expire_c = en && (cnt == '0);
  assign skip_c   = (SETTLE_CYCLES == 0);

endmodule

// File: rtl/tabla_sweep_checker.sv
// Drives every input row onto a combinational table module, samples its output after a
// settle delay and compares against a latched expected mask.
module tabla_sweep_checker
  import tabla_pkg::*;
#(
  parameter int unsigned N_IN          = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [num_vec(N_IN)-1:0]  expected,
  output logic [N_IN-1:0]           dut_in,
  input  logic                      dut_y,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [num_vec(N_IN)-1:0]  captured,
  output logic [N_IN:0]             mismatch_count,
  output logic [N_IN-1:0]           first_fail_idx,
  output logic                      first_fail_valid
);

  localparam int unsigned       NV       = num_vec(N_IN);
  localparam logic [N_IN-1:0]   LAST_IDX = N_IN'(NV - 1);

  logic [1:0]      state;
  logic [1:0]      state_next;
  logic            load_c;
  logic            expire_c;
  logic            skip_c;
  logic [N_IN-1:0] idx;
  logic [NV-1:0]   exp_q;
  logic            is_last_c;
  logic            miss_c;
  logic [N_IN:0]   mm_next_c;

  tabla_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load_c),
    .en       (state == ST_SETTLE),
    .expire_c (expire_c),
    .skip_c   (skip_c)
  );

  assign is_last_c = (idx == LAST_IDX);
  assign miss_c    = (dut_y != exp_q[idx]);
  assign mm_next_c = mismatch_count + (N_IN+1)'(miss_c);
  assign dut_in    = idx;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state; load re-arms the settle timer whenever a new row is presented.
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load_c     = 1'b1;
          state_next = skip_c ? ST_SAMPLE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (expire_c) state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (is_last_c) begin
          state_next = ST_DONE;
        end else begin
          load_c     = 1'b1;
          state_next = skip_c ? ST_SAMPLE : ST_SETTLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Row index, capture and scoreboard registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx              <= '0;
      exp_q            <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      captured         <= '0;
      mismatch_count   <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            idx              <= '0;
            exp_q            <= expected;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            captured         <= '0;
            mismatch_count   <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
          end
        end
        ST_SAMPLE: begin
          captured[idx] <= dut_y;
          if (miss_c) begin
            mismatch_count <= mm_next_c;
            if (!first_fail_valid) begin
              first_fail_idx   <= idx;
              first_fail_valid <= 1'b1;
            end
          end
          if (is_last_c) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (mm_next_c == '0);
          end else begin
            idx <= idx + N_IN'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
